i2c_txn_ctrl: RTL and testbench

- Register-level transaction sequencer directly upstream of the bit-level I2C master (the block owning the data1..data4 / data_end phases).
- Accepts one register write or register read request, breaks it into master commands (START, WR, RESTART, RD, STOP), and issues each command on the master's command interface.
- Consumes the master's done tick, ack and read-data outputs, then returns a single response with read data and an error code.

---
 rtl/i2c_txn_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_i2c_txn_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_ctrl.sv
// Register-level I2C transaction sequencer: turns one register read/write request into
// START/WR/RESTART/RD/STOP commands for a bit-level master and returns one response.
module i2c_txn_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rnw,
  input  logic [6:0] req_dev_addr,
  input  logic [7:0] req_reg_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [1:0] rsp_err,
  output logic [7:0] rsp_rdata,
  output logic [2:0] m_cmd,
  output logic [7:0] m_din,
  output logic       m_wr,
  input  logic       m_ready,
  input  logic       m_done_tick,
  input  logic       m_ack,
  input  logic [7:0] m_dout
);

  localparam logic [2:0] CmdStart   = 3'b000;
  localparam logic [2:0] CmdWr      = 3'b001;
  localparam logic [2:0] CmdRd      = 3'b010;
  localparam logic [2:0] CmdStop    = 3'b011;
  localparam logic [2:0] CmdRestart = 3'b100;

  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrNack    = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYCLES);
  // Control commands may only complete from the second cycle after the strobe,
  // so a master that drops m_ready one cycle late is not mistaken for done.
  localparam logic [CNT_W-1:0] CtlSettle  = CNT_W'(2);

  localparam logic [2:0] LastStepWr = 3'd4;
  localparam logic [2:0] LastStepRd = 3'd6;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e           r_state;
  logic             r_req_ready;
  logic             r_rnw;
  logic [6:0]       r_dev;
  logic [7:0]       r_reg;
  logic [7:0]       r_wdata;
  logic [2:0]       r_step;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp_valid;
  logic [1:0]       r_err;
  logic [7:0]       r_rdata;
  logic [2:0]       r_m_cmd;
  logic [7:0]       r_m_din;
  logic             r_m_wr;

  logic [2:0] w_cmd;
  logic [7:0] w_din;
  logic [2:0] w_last_step;
  logic       w_byte_cmd;
  logic       w_timeout;
  logic       w_complete;

  // Command and payload for the current step of the selected step list.
  always_comb begin
    w_cmd = CmdStop;
    w_din = 8'h00;
    if (r_rnw) begin
      case (r_step)
        3'd0: w_cmd = CmdStart;
        3'd1: begin w_cmd = CmdWr; w_din = {r_dev, 1'b0}; end
        3'd2: begin w_cmd = CmdWr; w_din = r_reg; end
        3'd3: w_cmd = CmdRestart;
        3'd4: begin w_cmd = CmdWr; w_din = {r_dev, 1'b1}; end
        3'd5: begin w_cmd = CmdRd; w_din = 8'h01; end
        default: w_cmd = CmdStop;
      endcase
    end else begin
      case (r_step)
        3'd0: w_cmd = CmdStart;
        3'd1: begin w_cmd = CmdWr; w_din = {r_dev, 1'b0}; end
        3'd2: begin w_cmd = CmdWr; w_din = r_reg; end
        3'd3: begin w_cmd = CmdWr; w_din = r_wdata; end
        default: w_cmd = CmdStop;
      endcase
    end
  end

  always_comb begin
    w_last_step = r_rnw ? LastStepRd : LastStepWr;
    w_byte_cmd  = (r_m_cmd == CmdWr) || (r_m_cmd == CmdRd);
    w_timeout   = (r_cnt == TimeoutVal);
    w_complete  = w_byte_cmd ? m_done_tick : (m_ready && (r_cnt >= CtlSettle));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_req_ready <= 1'b1;
      r_rnw       <= 1'b0;
      r_dev       <= 7'h00;
      r_reg       <= 8'h00;
      r_wdata     <= 8'h00;
      r_step      <= 3'd0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_err       <= ErrOk;
      r_rdata     <= 8'h00;
      r_m_cmd     <= CmdStop;
      r_m_din     <= 8'h00;
      r_m_wr      <= 1'b0;
    end else begin
      r_m_wr      <= 1'b0;
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (req_valid && r_req_ready) begin
            r_rnw       <= req_rnw;
            r_dev       <= req_dev_addr;
            r_reg       <= req_reg_addr;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            r_step      <= 3'd0;
            r_cnt       <= '0;
            r_err       <= ErrOk;
            r_rdata     <= 8'h00;
            r_state     <= StIssue;
          end
        end
        StIssue: begin
          if (m_ready) begin
            r_m_cmd <= w_cmd;
            r_m_din <= w_din;
            r_m_wr  <= 1'b1;
            r_cnt   <= '0;
            r_state <= StWait;
          end else if (w_timeout) begin
            r_err       <= ErrTimeout;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StWait: begin
          // Completion wins over a timeout landing in the same cycle.
          if (w_complete) begin
            if (r_m_cmd == CmdRd) begin
              r_rdata <= m_dout;
            end
            if ((r_m_cmd == CmdWr) && m_ack) begin
              r_err   <= ErrNack;
              r_step  <= w_last_step;
              r_cnt   <= '0;
              r_state <= StIssue;
            end else if (r_step == w_last_step) begin
              r_rsp_valid <= 1'b1;
              r_state     <= StResp;
            end else begin
              r_step  <= r_step + 3'd1;
              r_cnt   <= '0;
              r_state <= StIssue;
            end
          end else if (w_timeout) begin
            // Master presumed hung: respond without attempting a STOP.
            r_err       <= ErrTimeout;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StResp: begin
          r_req_ready <= 1'b1;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_err;
  assign rsp_rdata = r_rdata;
  assign m_cmd     = r_m_cmd;
  assign m_din     = r_m_din;
  assign m_wr      = r_m_wr;

endmodule

// File: tb/tb_i2c_txn_ctrl.sv
// Bench for i2c_txn_ctrl: behavioural I2C master stub plus a transaction-level model of the
// expected command sequence, error code and read data.
module tb_i2c_txn_ctrl;

  localparam int unsigned To = 20;

  localparam logic [2:0] CmdStart   = 3'b000;
  localparam logic [2:0] CmdWr      = 3'b001;
  localparam logic [2:0] CmdRd      = 3'b010;
  localparam logic [2:0] CmdStop    = 3'b011;
  localparam logic [2:0] CmdRestart = 3'b100;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rnw = 1'b0;
  logic [6:0] req_dev_addr = 7'h00;
  logic [7:0] req_reg_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic [1:0] rsp_err;
  logic [7:0] rsp_rdata;
  logic [2:0] m_cmd;
  logic [7:0] m_din;
  logic       m_wr;
  logic       m_ready;
  logic       m_done_tick;
  logic       m_ack;
  logic [7:0] m_dout;

  always #5 clk = ~clk;

  i2c_txn_ctrl #(.TIMEOUT_CYCLES(To), .CNT_W(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rnw     (req_rnw),
    .req_dev_addr(req_dev_addr),
    .req_reg_addr(req_reg_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_rdata   (rsp_rdata),
    .m_cmd       (m_cmd),
    .m_din       (m_din),
    .m_wr        (m_wr),
    .m_ready     (m_ready),
    .m_done_tick (m_done_tick),
    .m_ack       (m_ack),
    .m_dout      (m_dout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Response / acceptance monitor.
  int         rsp_cnt = 0;
  int         rsp_cyc = 0;
  int         acc_cnt = 0;
  int         acc_cyc = 0;
  logic [1:0] rsp_err_s;
  logic [7:0] rsp_rdata_s;
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_cyc     = cyc;
        rsp_err_s   = rsp_err;
        rsp_rdata_s = rsp_rdata;
      end
      if (reset_n && req_valid && req_ready) begin
        acc_cnt++;
        acc_cyc = cyc;
      end
    end
  end

  // Master stub configuration and observed strobes.
  int         cfg_nack_at = -1;
  int         cfg_hang_idx = -1;
  logic [7:0] cfg_dout = 8'h00;
  int         wr_cnt = 0;
  logic [2:0] obs_cmd[$];
  logic [7:0] obs_din[$];
  int         obs_cyc[$];

  initial begin
    bit         ms_busy, ms_done_sent, ms_hang, ms_ack;
    int         ms_lat, ms_idx;
    logic [2:0] ms_cmd;
    ms_busy = 0; ms_done_sent = 0; ms_hang = 0; ms_ack = 0; ms_lat = 0; ms_idx = 0;
    ms_cmd = CmdStop;
    m_ready = 1'b1; m_done_tick = 1'b0; m_ack = 1'b0; m_dout = 8'h00;
    forever begin
      @(negedge clk);
      m_done_tick = 1'b0;
      if (!reset_n) begin
        ms_busy = 0;
        m_ready = 1'b1;
      end else if (ms_busy) begin
        if (ms_hang) begin
          if (cfg_hang_idx != ms_idx) begin
            ms_busy = 0;
            m_ready = 1'b1;
          end
        end else if (ms_lat > 0) begin
          ms_lat--;
        end else if ((ms_cmd == CmdWr || ms_cmd == CmdRd) && !ms_done_sent) begin
          m_done_tick  = 1'b1;
          m_ack        = (ms_cmd == CmdWr) ? ms_ack : 1'($urandom_range(0, 1));
          m_dout       = (ms_cmd == CmdRd) ? cfg_dout : 8'($urandom);
          ms_done_sent = 1;
          ms_lat       = int'($urandom_range(0, 2));
        end else begin
          ms_busy = 0;
          m_ready = 1'b1;
        end
      end else if (m_wr) begin
        ms_idx = obs_cmd.size();
        obs_cmd.push_back(m_cmd);
        obs_din.push_back(m_din);
        obs_cyc.push_back(cyc);
        ms_cmd       = m_cmd;
        ms_busy      = 1;
        m_ready      = 1'b0;
        ms_done_sent = 0;
        ms_lat       = int'($urandom_range(0, 4));
        ms_hang      = (ms_idx == cfg_hang_idx);
        if (m_cmd == CmdWr) begin
          ms_ack = (wr_cnt == cfg_nack_at);
          wr_cnt++;
        end
      end
    end
  end

  // Transaction-level reference: expected strobes, error and read data.
  logic [2:0] exp_cmd[$];
  logic [7:0] exp_din[$];
  logic [1:0] exp_err;
  logic [7:0] exp_rdata;
  int         cur_hang;

  task automatic model_txn(input bit rnw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input logic [7:0] dout, input int nack_at,
                           input int hang_idx);
    logic [2:0] lc[$];
    logic [7:0] ld[$];
    int         wrn;
    wrn = 0;
    cur_hang = hang_idx;
    exp_cmd.delete(); exp_din.delete();
    exp_err = 2'b00; exp_rdata = 8'h00;
    lc.push_back(CmdStart); ld.push_back(8'h00);
    lc.push_back(CmdWr);    ld.push_back({dev, 1'b0});
    lc.push_back(CmdWr);    ld.push_back(rg);
    if (rnw) begin
      lc.push_back(CmdRestart); ld.push_back(8'h00);
      lc.push_back(CmdWr);      ld.push_back({dev, 1'b1});
      lc.push_back(CmdRd);      ld.push_back(8'h01);
    end else begin
      lc.push_back(CmdWr); ld.push_back(wd);
    end
    lc.push_back(CmdStop); ld.push_back(8'h00);
    for (int i = 0; i < lc.size(); i++) begin
      exp_cmd.push_back(lc[i]);
      exp_din.push_back(ld[i]);
      if (exp_cmd.size() - 1 == hang_idx) begin
        exp_err = 2'b10;
        return;
      end
      if (lc[i] == CmdRd) exp_rdata = dout;
      if (lc[i] == CmdWr) begin
        if (wrn == nack_at) begin
          exp_err = 2'b01;
          exp_cmd.push_back(CmdStop);
          exp_din.push_back(8'h00);
          if (exp_cmd.size() - 1 == hang_idx) exp_err = 2'b10;
          return;
        end
        wrn++;
      end
    end
  endtask

  task automatic start_cfg(input logic [7:0] dout, input int nack_at, input int hang_idx);
    cfg_dout = dout; cfg_nack_at = nack_at; cfg_hang_idx = hang_idx;
    obs_cmd.delete(); obs_din.delete(); obs_cyc.delete();
    wr_cnt = 0;
  endtask

  task automatic send_req(input string tag, input bit rnw, input logic [6:0] dev,
                          input logic [7:0] rg, input logic [7:0] wd);
    int a0;
    a0 = acc_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_rnw = rnw; req_dev_addr = dev; req_reg_addr = rg; req_wdata = wd;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      if (acc_cnt != a0) break;
    end
    check_eq({tag, ".acc"}, acc_cnt, a0 + 1);
    #1;
    req_valid = 1'b0;
    req_rnw = 1'($urandom); req_dev_addr = 7'($urandom);
    req_reg_addr = 8'($urandom); req_wdata = 8'($urandom);
  endtask

  task automatic finish_check(input string tag, input int r0, input bit b2b);
    for (int k = 0; k < 1500; k++) begin
      @(posedge clk);
      if (rsp_cnt != r0) break;
    end
    check_eq({tag, ".rsp"}, rsp_cnt, r0 + 1);
    check_eq({tag, ".ncmd"}, obs_cmd.size(), exp_cmd.size());
    for (int i = 0; i < exp_cmd.size(); i++) begin
      if (i < obs_cmd.size()) begin
        check_eq($sformatf("%s.cmd%0d", tag, i), obs_cmd[i], exp_cmd[i]);
        if (exp_cmd[i] == CmdWr || exp_cmd[i] == CmdRd)
          check_eq($sformatf("%s.din%0d", tag, i), obs_din[i], exp_din[i]);
      end
    end
    check_eq({tag, ".err"}, rsp_err_s, exp_err);
    check_eq({tag, ".rdata"}, rsp_rdata_s, exp_rdata);
    if (exp_err == 2'b10 && cur_hang >= 0 && cur_hang < obs_cyc.size())
      check_eq({tag, ".to_lat"}, rsp_cyc - obs_cyc[cur_hang], To + 1);
    cfg_hang_idx = -1;
    if (!b2b) begin
      repeat (3) @(posedge clk);
      check_eq({tag, ".once"}, rsp_cnt, r0 + 1);
      check_eq({tag, ".err_hold"}, rsp_err, exp_err);
    end
  endtask

  task automatic run_txn(input string tag, input bit rnw, input logic [6:0] dev,
                         input logic [7:0] rg, input logic [7:0] wd, input logic [7:0] dout,
                         input int nack_at, input int hang_idx);
    int r0;
    start_cfg(dout, nack_at, hang_idx);
    model_txn(rnw, dev, rg, wd, dout, nack_at, hang_idx);
    r0 = rsp_cnt;
    send_req(tag, rnw, dev, rg, wd);
    finish_check(tag, r0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycles %0d", cyc);
    $fatal(1, "bench stopped by watchdog");
  end

  initial begin
    int r0, a0, rc_a;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #2;
    check_eq("rst.req_ready", req_ready, 1);
    check_eq("rst.rsp_valid", rsp_valid, 0);
    check_eq("rst.rsp_err", rsp_err, 0);
    check_eq("rst.rsp_rdata", rsp_rdata, 0);
    check_eq("rst.m_wr", m_wr, 0);
    check_eq("rst.m_cmd", m_cmd, 3);
    check_eq("rst.m_din", m_din, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    run_txn("wr", 1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, -1);
    run_txn("rd", 1'b1, 7'h50, 8'h10, 8'h00, 8'h3C, -1, -1);
    run_txn("nack_addr", 1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 0, -1);
    run_txn("to_start", 1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, 0);
    run_txn("nack_to_stop", 1'b1, 7'h2A, 8'h07, 8'h00, 8'h11, 1, 3);

    // Second request held pending while the first runs.
    start_cfg(8'h00, -1, -1);
    model_txn(1'b0, 7'h21, 8'h04, 8'h99, 8'h00, -1, -1);
    r0 = rsp_cnt; a0 = acc_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_rnw = 1'b0; req_dev_addr = 7'h21; req_reg_addr = 8'h04;
    req_wdata = 8'h99;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      if (acc_cnt != a0) break;
    end
    check_eq("b2b.accA", acc_cnt, a0 + 1);
    #1;
    req_rnw = 1'b1; req_dev_addr = 7'h33; req_reg_addr = 8'h44; req_wdata = 8'h55;
    finish_check("b2b.A", r0, 1'b1);
    start_cfg(8'h6E, -1, -1);
    model_txn(1'b1, 7'h33, 8'h44, 8'h55, 8'h6E, -1, -1);
    r0 = rsp_cnt; a0 = acc_cnt; rc_a = rsp_cyc;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      if (acc_cnt != a0) break;
    end
    check_eq("b2b.accB", acc_cnt, a0 + 1);
    check_eq("b2b.acc_lat", acc_cyc, rc_a + 1);
    #1 req_valid = 1'b0;
    finish_check("b2b.B", r0, 1'b0);

    // Reset during WAIT of the register-address WR.
    start_cfg(8'h00, -1, -1);
    r0 = rsp_cnt;
    send_req("rst_mid", 1'b0, 7'h50, 8'h10, 8'hA5);
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (obs_cmd.size() >= 3) break;
    end
    check_eq("rst_mid.pre", obs_cmd.size(), 3);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_mid.req_ready", req_ready, 1);
    check_eq("rst_mid.m_wr", m_wr, 0);
    check_eq("rst_mid.m_cmd", m_cmd, 3);
    check_eq("rst_mid.m_din", m_din, 0);
    check_eq("rst_mid.rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (8) @(posedge clk);
    check_eq("rst_mid.norsp", rsp_cnt, r0);
    run_txn("post_rst", 1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, -1);

    for (int i = 0; i < 40; i++) begin
      bit         rnw;
      logic [6:0] dev;
      logic [7:0] rg, wd, dout;
      int         nack, hang;
      rnw  = 1'($urandom_range(0, 1));
      dev  = 7'($urandom);
      rg   = 8'($urandom);
      wd   = 8'($urandom);
      dout = 8'($urandom);
      nack = int'($urandom_range(0, 5));
      hang = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_txn($sformatf("rnd%0d", i), rnw, dev, rg, wd, dout, nack, hang);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
